// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared states and constants for the multi-cycle sequencer
package cpu_mc_pkg;
  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_PC4 = 2'd1;
  localparam logic [1:0] WBSEL_LOAD = 2'd2;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts un-acked request cycles, expires on the TIMEOUT-th one
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  // fires in the cycle whose increment brings count to TIMEOUT; constant-false when disabled
  assign expired = (TIMEOUT != 0) && en && count == W'(TIMEOUT - 1);
endmodule

// File: rtl/cpu_mc_ctrl.sv
// cpu_mc_ctrl: multi-cycle RV32I sequencer with req/ack memory ports and wait-state trap
module cpu_mc_ctrl
  import cpu_mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  input  logic              dec_jmpe,
  input  logic              dec_br_taken,
  input  logic              dec_we,
  input  logic              dec_ld,
  input  logic              dec_st,
  input  logic [1:0]        dec_wbsel,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              rf_we,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              retire,
  output logic              trap
);
  state_t state, state_nx;
  logic [XLEN-1:0] alu_q, st_q, ld_q;
  logic [ADDR_W-1:0] target;
  logic jump, mis, fetch_ack, mem_ack, expired;
  assign pc_next = pc + ADDR_W'(4);
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign dmem_req = state == MEM;
  assign dmem_we = dmem_req & dec_st;
  assign dmem_addr = alu_q[ADDR_W-1:0];
  assign dmem_wdata = st_q;
  assign fetch_ack = imem_req & imem_ack;
  assign mem_ack = dmem_req & dmem_ack;
  assign jump = dec_jmpe | dec_br_taken;
  assign target = {alu_q[ADDR_W-1:1], 1'b0};
  assign mis = jump & target[1];
  assign retire = state == WB;
  assign rf_we = retire & dec_we & ~dec_st & ~mis;
  assign rf_wdata = dec_wbsel == WBSEL_PC4 ? XLEN'(pc_next) :
                    dec_wbsel == WBSEL_LOAD ? ld_q : alu_q;
  assign trap = state == TRAP;
  // timer sits at zero outside the two request states, so each request starts from zero
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(~(imem_req | dmem_req)),
    .en((imem_req & ~imem_ack) | (dmem_req & ~dmem_ack)),
    .expired(expired)
  );
  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   state_nx = fetch_ack ? DECODE : expired ? TRAP : FETCH;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (dec_ld | dec_st) ? MEM : WB;
      MEM:     state_nx = mem_ack ? WB : expired ? TRAP : MEM;
      WB:      state_nx = mis ? TRAP : FETCH;
      default: state_nx = TRAP;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      ir <= NOP_INSN;
      alu_q <= '0;
      st_q <= '0;
      ld_q <= '0;
    end else begin
      state <= state_nx;
      if (fetch_ack) ir <= imem_rdata;
      if (state == EXEC) begin
        alu_q <= alu_res;
        st_q <= rs2_data;
      end
      if (mem_ack && dec_ld) ld_q <= dmem_rdata;
      if (retire && !mis) pc <= jump ? target : pc_next;
    end
endmodule
